// File: rtl/connect4_pkg.sv
// Shared Connect-Four constants and column type.
// Used by the column-height encoder and its bench.
package connect4_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int HW   = 3;

  typedef logic [ROWS-1:0] column_t;
endpackage

// File: rtl/my_log_prienc.sv
// Highest-set-bit priority encoder for a column.
// Returns the index of the top set bit and an any-bit flag.
module my_log_prienc #(
  parameter int ROWS = 6,
  parameter int HW   = 3
) (
  input  logic [ROWS-1:0] onoff_i,
  output logic [HW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |onoff_i;
    // Ascending scan: the last hit is the highest bit.
    for (int i = 0; i < ROWS; i++) begin
      if (onoff_i[i]) idx_o = HW'(i);
    end
  end

endmodule

// File: rtl/my_log.sv
// Column-height encoder: registered height, legality
// and full/empty/next-free flags with a valid strobe.
module my_log #(
  parameter int ROWS = 6,
  parameter int HW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [ROWS-1:0] onoff,
  output logic [HW-1:0]   height,
  output logic            valid,
  output logic            err,
  output logic            full,
  output logic            empty,
  output logic [ROWS-1:0] next_free
);

  import connect4_pkg::*;

  logic [HW-1:0]   idx;
  logic            any;
  logic [HW-1:0]   ht;
  logic [HW-1:0]   pop;
  logic [ROWS-1:0] nf;

  logic [HW-1:0]   height_q, height_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [ROWS-1:0] nf_q, nf_d;

  my_log_prienc #(
    .ROWS(ROWS),
    .HW  (HW)
  ) u_prienc (
    .onoff_i(onoff),
    .idx_o  (idx),
    .any_o  (any)
  );

  always_comb begin
    ht  = any ? idx + HW'(1) : '0;
    pop = '0;
    for (int i = 0; i < ROWS; i++) begin
      pop = pop + HW'(onoff[i]);
    end
    nf = '0;
    if (ht < HW'(ROWS)) nf[ht] = 1'b1;
  end

  always_comb begin
    height_d = height_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    full_d   = full_q;
    empty_d  = empty_q;
    nf_d     = nf_q;
    if (go) begin
      height_d = ht;
      valid_d  = 1'b1;
      err_d    = (pop != ht);
      full_d   = (ht == HW'(ROWS));
      empty_d  = (ht == '0);
      nf_d     = nf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      height_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      nf_q     <= ROWS'(1);
    end else begin
      height_q <= height_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      nf_q     <= nf_d;
    end
  end

  assign height    = height_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign next_free = nf_q;

endmodule

// File: tb/tb_my_log.sv
// Bench for my_log: directed cases then random
// traffic against a behavioural column model.
module tb_my_log;
  import connect4_pkg::*;

  logic          clk = 1'b0;
  logic          reset, go;
  column_t       onoff;
  logic [HW-1:0] height;
  logic          valid, err, full, empty;
  column_t       next_free;

  int checks = 0;
  int errors = 0;

  int      e_h;
  logic    e_v, e_e, e_f, e_m;
  column_t e_nf;

  my_log #(.ROWS(ROWS), .HW(HW)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .onoff    (onoff),
    .height   (height),
    .valid    (valid),
    .err      (err),
    .full     (full),
    .empty    (empty),
    .next_free(next_free)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int top_height(input column_t c);
    int h = 0;
    for (int i = 0; i < ROWS; i++)
      if (c[i]) h = i + 1;
    return h;
  endfunction

  task automatic cyc(input logic r,
                     input logic g,
                     input column_t o);
    reset = r;
    go    = g;
    onoff = o;
    @(posedge clk);
    #1;
    if (r) begin
      e_h = 0; e_v = 0; e_e = 0;
      e_f = 0; e_m = 1; e_nf = column_t'(1);
    end else if (g) begin
      e_h  = top_height(o);
      e_v  = 1;
      e_e  = ($countones(o) != e_h);
      e_f  = (e_h == ROWS);
      e_m  = (e_h == 0);
      e_nf = (e_h < ROWS) ? column_t'(1 << e_h) : '0;
    end else begin
      e_v = 0;
    end
    check("height", int'(height), e_h);
    check("valid", int'(valid), int'(e_v));
    check("err", int'(err), int'(e_e));
    check("full", int'(full), int'(e_f));
    check("empty", int'(empty), int'(e_m));
    check("next_free", int'(next_free), int'(e_nf));
  endtask

  initial begin
    column_t c;
    reset = 1'b1; go = 1'b0; onoff = '0;
    cyc(1, 1, 6'b111111);
    cyc(1, 1, 6'b111111);
    check("rst_h", int'(height), 0);
    check("rst_nf", int'(next_free), 1);

    cyc(0, 1, 6'b000000);
    cyc(0, 1, 6'b000001);
    cyc(0, 1, 6'b000111);
    cyc(0, 1, 6'b011111);
    cyc(0, 1, 6'b111111);
    check("full6", int'(full), 1);

    cyc(0, 1, 6'b000101);
    check("ill_h3", int'(height), 3);
    cyc(0, 1, 6'b100000);
    check("ill_h6", int'(height), 6);

    cyc(0, 1, 6'b000011);
    cyc(0, 0, 6'b111111);
    cyc(0, 0, 6'b111111);
    cyc(0, 0, 6'b111111);
    check("hold_h", int'(height), 2);

    cyc(1, 1, 6'b001111);
    cyc(0, 1, 6'b001111);
    check("prio_h", int'(height), 4);

    cyc(0, 1, 6'b000111);
    cyc(1, 0, 6'b000111);
    check("rst_after", int'(height), 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(1) == 1)
        c = column_t'((1 << $urandom_range(ROWS)) - 1);
      else
        c = column_t'($urandom);
      cyc(($urandom_range(19) == 0),
          ($urandom_range(9) < 7), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
